// File: rtl/adc_uart_framer.sv
// ADC sample FIFO and byte framer feeding uart_tx: {SYNC_NIBBLE, s[11:8]}, s[7:0].
// Define FRAMER_CHECKSUM_EN to append a third byte (HI ^ LO) to every frame.
module adc_uart_framer #(
    parameter int          SAMPLE_BITS = 12,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [3:0]  SYNC_NIBBLE = 4'hA
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [SAMPLE_BITS-1:0]       i_sample,
    input  logic                         i_sample_valid,
    input  logic                         i_tx_ready,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_enb,
    output logic                         o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

`ifdef FRAMER_CHECKSUM_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HI = 2'd1, ST_LO = 2'd2, ST_CHK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HI = 2'd1, ST_LO = 2'd2} state_t;
`endif

    function automatic logic [7:0] hi_byte(input logic [11:0] s);
        return {SYNC_NIBBLE, s[11:8]};
    endfunction

`ifdef FRAMER_CHECKSUM_EN
    function automatic logic [7:0] chk_byte(input logic [11:0] s);
        return hi_byte(s) ^ s[7:0];
    endfunction
`endif

    state_t       state_r, state_nx_s;
    logic [11:0]  mem_r [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_r, rd_ptr_r, level_r;
    logic [11:0]  sample_r, head_s, sample_ext_s;
    logic [7:0]   tx_data_r, tx_data_nx_s;
    logic         tx_enb_r, overflow_r;
    logic         full_s, empty_s, push_s, pop_s, accept_s;

    assign sample_ext_s = 12'(i_sample);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s   = mem_r[rd_ptr_r[AW-1:0]];
    // A full FIFO still takes a sample in the same cycle the framer pops one.
    assign push_s   = i_sample_valid && (!full_s || pop_s);
    assign accept_s = tx_enb_r && i_tx_ready;

    // Next-state logic; pop_s loads the FIFO head into sample_r at the HI transition.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_HI;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HI: begin
                if (accept_s) state_nx_s = ST_LO;
                else          state_nx_s = ST_HI;
            end
`ifdef FRAMER_CHECKSUM_EN
            ST_LO: begin
                if (accept_s) state_nx_s = ST_CHK;
                else          state_nx_s = ST_LO;
            end
            ST_CHK: begin
`else
            ST_LO: begin
`endif
                if (accept_s && !empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_HI;
                end else if (accept_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next byte to present, registered below so o_tx_enb has no path from i_tx_ready.
    always_comb begin
        tx_data_nx_s = 8'h00;
        case (state_nx_s)
            ST_HI: begin
                if (pop_s) tx_data_nx_s = hi_byte(head_s);
                else       tx_data_nx_s = tx_data_r;
            end
            ST_LO:   tx_data_nx_s = sample_r[7:0];
`ifdef FRAMER_CHECKSUM_EN
            ST_CHK:  tx_data_nx_s = chk_byte(sample_r);
`endif
            default: tx_data_nx_s = 8'h00;
        endcase
    end

    // FSM state, current sample and registered TX outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            sample_r  <= 12'h000;
            tx_data_r <= 8'h00;
            tx_enb_r  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            tx_data_r <= tx_data_nx_s;
            tx_enb_r  <= (state_nx_s != ST_IDLE);
            if (pop_s) sample_r <= head_s;
        end
    end

    // FIFO pointers, level and sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + ONE;
            if (push_s && !pop_s)      level_r <= level_r + ONE;
            else if (!push_s && pop_s) level_r <= level_r - ONE;
            if (i_sample_valid && full_s && !pop_s) overflow_r <= 1'b1;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= sample_ext_s;
    end

    assign o_tx_data    = tx_data_r;
    assign o_tx_enb     = tx_enb_r;
    assign o_overflow   = overflow_r;
    assign o_fifo_level = level_r;

endmodule

// File: tb/tb_adc_uart_framer.sv
// Scoreboard bench for adc_uart_framer; honours FRAMER_CHECKSUM_EN for frame length.
module tb_adc_uart_framer;

`ifdef FRAMER_CHECKSUM_EN
    localparam int FB = 3;
`else
    localparam int FB = 2;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sample = 12'h000;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_enb, overflow;
    logic [3:0]  level;

    logic [7:0]  exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          bytes_seen = 0;

    adc_uart_framer #(.SAMPLE_BITS(12), .FIFO_DEPTH(DEPTH), .SYNC_NIBBLE(4'hA)) dut (
        .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_sample_valid(valid),
        .i_tx_ready(ready), .o_tx_data(tx_data), .o_tx_enb(tx_enb),
        .o_overflow(overflow), .o_fifo_level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [11:0] s);
        logic [7:0] hi, lo;
        hi = {4'hA, s[11:8]};
        lo = s[7:0];
        exp_q.push_back(hi);
        exp_q.push_back(lo);
`ifdef FRAMER_CHECKSUM_EN
        exp_q.push_back(hi ^ lo);
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        // Monitor: every accepted byte is popped from the scoreboard and compared.
        fork
            forever begin
                @(negedge clk);
                if (!rst && tx_enb && ready) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF);
                    else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
        join_none

        // Reset state
        do_reset(2);
        check("rst_enb", 32'(tx_enb), 32'd0);
        check("rst_data", 32'(tx_data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_level", 32'(level), 32'd0);

        // Single sample, latency and frame end
        ready = 1'b1;
        sample = 12'h5C3; valid = 1'b1; push_frame(12'h5C3);
        step();
        valid = 1'b0;
        check("lat_n1_enb", 32'(tx_enb), 32'd0);
        step();
        check("lat_n2_enb", 32'(tx_enb), 32'd1);
        check("lat_n2_data", 32'(tx_data), 32'hA5);
        wait_drain(20);
        check("t1_enb_low", 32'(tx_enb), 32'd0);
        check("t1_level", 32'(level), 32'd0);

        // Burst of 8 with ready held off, then back-to-back drain
        ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            sample = 12'(i); valid = 1'b1; push_frame(12'(i));
            step();
        end
        valid = 1'b0;
        step();
        check("burst_level", 32'(level), 32'd7);
        check("burst_ovf", 32'(overflow), 32'd0);
        ready = 1'b1;
        for (int i = 0; i < 8 * FB; i++) begin
            check("no_gap", 32'(tx_enb), 32'd1);
            step();
        end
        check("burst_end_enb", 32'(tx_enb), 32'd0);
        check("burst_q_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: fill register plus FIFO, one extra strobe is dropped
        ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            sample = 12'h0FF; valid = 1'b1;
            if (i < DEPTH + 1) push_frame(12'h0FF);
            step();
        end
        valid = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'(DEPTH));
        repeat (3) step();
        check("ovf_sticky", 32'(overflow), 32'd1);
        base = bytes_seen;
        ready = 1'b1;
        wait_drain(200);
        step();
        check("ovf_frames", 32'(bytes_seen - base), 32'((DEPTH + 1) * FB));
        check("ovf_sticky_end", 32'(overflow), 32'd1);
        check("ovf_idle", 32'(tx_enb), 32'd0);

        // Simultaneous push and pop while full
        do_reset(1);
        ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            sample = 12'h100 + 12'(i); valid = 1'b1; push_frame(12'h100 + 12'(i));
            step();
        end
        valid = 1'b0;
        check("full_level", 32'(level), 32'(DEPTH));
        ready = 1'b1;
        for (int k = 0; k < FB - 1; k++) step();
        sample = 12'h1AA; valid = 1'b1; push_frame(12'h1AA);
        step();
        valid = 1'b0; ready = 1'b0;
        check("pushpop_level", 32'(level), 32'(DEPTH));
        check("pushpop_ovf", 32'(overflow), 32'd0);
        ready = 1'b1;
        wait_drain(200);
        check("pushpop_ovf_end", 32'(overflow), 32'd0);

        // Reset between HI and LO abandons the frame
        do_reset(1);
        ready = 1'b0;
        sample = 12'h456; valid = 1'b1;
        exp_q.push_back(8'hA4);
        step();
        valid = 1'b0;
        for (int n = 0; n < 10 && !tx_enb; n++) step();
        check("t6_hi_up", 32'(tx_enb), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_enb", 32'(tx_enb), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_hi_taken", 32'(exp_q.size()), 32'd0);
        ready = 1'b1;
        sample = 12'h123; valid = 1'b1; push_frame(12'h123);
        step();
        valid = 1'b0;
        wait_drain(20);
        check("t6_end_enb", 32'(tx_enb), 32'd0);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
